// File: rtl/led_pkg.sv
// Shared definitions for the LED frame sequencer: state encoding and default sizing.
package led_pkg;

    localparam int DEFAULT_NUM_LEDS     = 150;
    localparam int DEFAULT_LATCH_CYCLES = 600;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        FETCH      = 3'd1,
        WAIT_PIXEL = 3'd2,
        ENCODE     = 3'd3,
        ADVANCE    = 3'd4,
        LATCH      = 3'd5
    } seq_state_t;

endpackage

// File: rtl/rising_edge_detect.sv
// Single-cycle rising-edge detector; stays quiet for the first cycle after reset
// so a level that is already high at release never looks like an edge.
module rising_edge_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic level,
    output logic rise
);

    logic prev_level;
    logic armed;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prev_level <= 1'b0;
            armed      <= 1'b0;
        end else begin
            prev_level <= level;
            armed      <= 1'b1;
        end
    end

    assign rise = armed & level & ~prev_level;

endmodule

// File: rtl/led_frame_sequencer.sv
// Walks a strip frame from the last LED down to LED 0, handshaking pixel fetch
// and serial encode for each LED, then holds the strip latch gap.
module led_frame_sequencer
    import led_pkg::*;
#(
    parameter int NUM_LEDS     = DEFAULT_NUM_LEDS,
    parameter int LATCH_CYCLES = DEFAULT_LATCH_CYCLES
) (
    input  logic       clock_12mhz,
    input  logic       reset_n,
    input  logic       framerate,
    output logic       pixel_read,
    input  logic       pixel_valid,
    output logic       encoder_start,
    input  logic       encoder_finished,
    output logic [7:0] led_index,
    output logic       busy,
    output logic       frame_done,
    output logic       overrun
);

    localparam int                CNT_W      = $clog2(LATCH_CYCLES + 1);
    localparam logic [7:0]        LAST_INDEX = 8'(NUM_LEDS - 1);
    localparam logic [CNT_W-1:0]  LATCH_LAST = CNT_W'(LATCH_CYCLES - 1);

    seq_state_t       state;
    seq_state_t       next_state;
    logic [CNT_W-1:0] latch_cnt;
    logic             start_pending;
    logic             tick;
    logic             latch_done;

    rising_edge_detect u_frame_tick (
        .clk     (clock_12mhz),
        .reset_n (reset_n),
        .level   (framerate),
        .rise    (tick)
    );

    assign latch_done = (state == LATCH) && (latch_cnt == LATCH_LAST);

    always_ff @(posedge clock_12mhz) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // start_pending marks the first ENCODE cycle, i.e. the cycle after pixel_valid was accepted
    always_ff @(posedge clock_12mhz) begin
        if (!reset_n) begin
            led_index     <= 8'd0;
            latch_cnt     <= '0;
            start_pending <= 1'b0;
        end else begin
            start_pending <= (state == WAIT_PIXEL) && pixel_valid;
            case (state)
                IDLE: begin
                    if (tick) begin
                        led_index <= LAST_INDEX;
                    end
                end
                ADVANCE: begin
                    if (led_index == 8'd0) begin
                        latch_cnt <= '0;
                    end else begin
                        led_index <= led_index - 8'd1;
                    end
                end
                LATCH: begin
                    latch_cnt <= latch_cnt + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:       if (tick) next_state = FETCH;
            FETCH:      next_state = WAIT_PIXEL;
            WAIT_PIXEL: if (pixel_valid) next_state = ENCODE;
            ENCODE:     if (encoder_finished) next_state = ADVANCE;
            ADVANCE:    next_state = (led_index == 8'd0) ? LATCH : FETCH;
            LATCH:      if (latch_done) next_state = IDLE;
            default:    next_state = IDLE;
        endcase
    end

    // Outputs are forced low during the reset cycle itself, not just after it
    always_comb begin
        pixel_read    = 1'b0;
        encoder_start = 1'b0;
        frame_done    = 1'b0;
        overrun       = 1'b0;
        busy          = 1'b0;
        if (reset_n) begin
            busy          = (state != IDLE);
            pixel_read    = (state == FETCH);
            encoder_start = (state == ENCODE) && start_pending;
            frame_done    = latch_done;
            overrun       = tick && (state != IDLE);
        end
    end

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Self-checking bench: a frame-offset model predicts every output each cycle while
// a responder answers pixel_read after 2 cycles and encoder_start after 5 cycles.
module tb_led_frame_sequencer;

    localparam int N       = 3;
    localparam int L       = 8;
    localparam int PV_LAT  = 2;
    localparam int EF_LAT  = 5;
    localparam int PER_LED = 1 + PV_LAT + (EF_LAT + 1) + 1;
    localparam int FRAME   = N * PER_LED + L;

    logic       clock_12mhz;
    logic       reset_n;
    logic       framerate;
    logic       pixel_read;
    logic       pixel_valid;
    logic       encoder_start;
    logic       encoder_finished;
    logic [7:0] led_index;
    logic       busy;
    logic       frame_done;
    logic       overrun;

    led_frame_sequencer #(.NUM_LEDS(N), .LATCH_CYCLES(L)) dut (
        .clock_12mhz      (clock_12mhz),
        .reset_n          (reset_n),
        .framerate        (framerate),
        .pixel_read       (pixel_read),
        .pixel_valid      (pixel_valid),
        .encoder_start    (encoder_start),
        .encoder_finished (encoder_finished),
        .led_index        (led_index),
        .busy             (busy),
        .frame_done       (frame_done),
        .overrun          (overrun)
    );

    initial clock_12mhz = 1'b0;
    always #5 clock_12mhz = ~clock_12mhz;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int pv_due   = -10;
    int ef_due   = -10;
    int tick_cyc = 0;

    bit m_active  = 0;
    int m_k       = 0;
    bit m_prev_fr = 0;
    bit m_prev_ok = 0;

    int obs_pr, obs_es, obs_fd, obs_ov, obs_busy, obs_fd_cyc;
    logic [7:0] obs_seq[$];

    task automatic cmp(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, want, cyc);
        end
    endtask

    function automatic int seqAt(input int i);
        if (i < obs_seq.size()) return int'(obs_seq[i]);
        return -1;
    endfunction

    task automatic clearObs();
        obs_pr = 0; obs_es = 0; obs_fd = 0; obs_ov = 0; obs_busy = 0; obs_fd_cyc = -1;
        obs_seq.delete();
    endtask

    // Expected outputs follow from the cycle offset k since the accepted tick
    task automatic checkOutput();
        bit tick;
        bit e_busy, e_pr, e_es, e_fd, e_ov;
        int e_idx, j;
        e_busy = 0; e_pr = 0; e_es = 0; e_fd = 0; e_ov = 0; e_idx = 0;
        if (reset_n) begin
            tick = framerate && !m_prev_fr && m_prev_ok;
            if (m_active) begin
                m_k++;
                e_busy = 1;
                e_ov   = tick;
                j = m_k - 1;
                if (j < N * PER_LED) begin
                    e_idx = N - 1 - j / PER_LED;
                    e_pr  = (j % PER_LED == 0);
                    e_es  = (j % PER_LED == 1 + PV_LAT);
                end
                if (m_k == FRAME) begin
                    e_fd = 1;
                    m_active = 0;
                end
            end else if (tick) begin
                m_active = 1;
                m_k = 0;
            end
            cmp("led_index", int'(led_index), e_idx);
        end else begin
            m_active = 0;
        end
        m_prev_fr = framerate;
        m_prev_ok = reset_n;

        cmp("busy", int'(busy), int'(e_busy));
        cmp("pixel_read", int'(pixel_read), int'(e_pr));
        cmp("encoder_start", int'(encoder_start), int'(e_es));
        cmp("frame_done", int'(frame_done), int'(e_fd));
        cmp("overrun", int'(overrun), int'(e_ov));

        if (pixel_read) begin
            obs_pr++;
            obs_seq.push_back(led_index);
            pv_due = cyc + PV_LAT;
        end
        if (encoder_start) begin
            obs_es++;
            ef_due = cyc + EF_LAT;
        end
        if (frame_done) begin
            obs_fd++;
            obs_fd_cyc = cyc;
        end
        if (overrun) obs_ov++;
        if (busy) obs_busy++;
    endtask

    task automatic applyStimulus(input logic rst_v, input logic fr_v,
                                 input logic stray_pv, input logic stray_ef);
        @(negedge clock_12mhz);
        cyc++;
        reset_n          = rst_v;
        framerate        = fr_v;
        pixel_valid      = stray_pv || (cyc == pv_due);
        encoder_finished = stray_ef || (cyc == ef_due);
        #1;
        checkOutput();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tickNow();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        tick_cyc = cyc;
    endtask

    initial begin
        reset_n = 1'b0; framerate = 1'b0; pixel_valid = 1'b0; encoder_finished = 1'b0;
        clearObs();

        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);
        cmp("reset_led_index", int'(led_index), 0);
        cmp("reset_busy", int'(busy), 0);
        idle(1);

        // Nominal frame
        clearObs();
        tickNow();
        idle(FRAME);
        idle(3);
        cmp("nom_reads", obs_pr, 3);
        cmp("nom_starts", obs_es, 3);
        cmp("nom_seq0", seqAt(0), 2);
        cmp("nom_seq1", seqAt(1), 1);
        cmp("nom_seq2", seqAt(2), 0);
        cmp("nom_done_count", obs_fd, 1);
        cmp("nom_latency", obs_fd_cyc - tick_cyc, 38);
        cmp("nom_busy_after", int'(busy), 0);

        // Second tick while encoding LED 1
        clearObs();
        tickNow();
        idle(14);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        idle(FRAME - 15);
        idle(3);
        cmp("ovr_pulses", obs_ov, 1);
        cmp("ovr_starts", obs_es, 3);
        cmp("ovr_done_count", obs_fd, 1);
        cmp("ovr_latency", obs_fd_cyc - tick_cyc, 38);

        // Stray encoder_finished in FETCH and pixel_valid in ENCODE
        clearObs();
        tickNow();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        idle(3);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        idle(FRAME - 5);
        idle(3);
        cmp("stray_seq0", seqAt(0), 2);
        cmp("stray_seq1", seqAt(1), 1);
        cmp("stray_seq2", seqAt(2), 0);
        cmp("stray_latency", obs_fd_cyc - tick_cyc, 38);

        // Reset during WAIT_PIXEL of LED 1
        clearObs();
        tickNow();
        idle(11);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);
        cmp("abort_busy", int'(busy), 0);
        cmp("abort_led_index", int'(led_index), 0);
        idle(44);
        cmp("abort_no_done", obs_fd, 0);

        clearObs();
        tickNow();
        idle(FRAME);
        cmp("restart_seq0", seqAt(0), 2);
        cmp("restart_done_count", obs_fd, 1);

        // Back-to-back: tick the cycle right after frame_done
        clearObs();
        tickNow();
        idle(FRAME);
        idle(3);
        cmp("b2b_overrun", obs_ov, 0);
        cmp("b2b_starts", obs_es, 3);
        cmp("b2b_latency", obs_fd_cyc - tick_cyc, 38);

        // Reset released while framerate is already high
        clearObs();
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        cmp("high_release_busy", obs_busy, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        clearObs();
        tickNow();
        idle(FRAME);
        idle(2);
        cmp("high_release_done", obs_fd, 1);
        cmp("high_release_latency", obs_fd_cyc - tick_cyc, 38);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
